branch_resolve_bht: RTL and testbench

//  Parametrised successor to the D-stage branch comparator. Resolves conditional branches
//  (BEQ/BNE/BLEZ/BGTZ/BLTZ/BGEZ/BLTZAL/BGEZAL) at width DATA_W.

---
 rtl/branch_resolve_bht.sv | 131 +++++++++++++
 tb/tb_branch_resolve_bht.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_bht.sv
// branch_resolve_bht
//   D-stage conditional-branch resolver with a direct-mapped table of 2-bit
//   saturating counters used for F-stage prediction, plus saturating
//   branch / mispredict statistics.
// Ports
//   clk, reset_n                 clock, async active-low reset
//   f_pc -> f_pred_taken         F-stage lookup (with same-cycle write bypass)
//   d_valid, d_stall, d_is_br,
//   d_opcode, d_rt, d_pc,
//   d_pred_taken, d_rd1, d_rd2   D-stage branch being resolved
//   br_taken, br_link,
//   mispredict                   combinational resolve results
//   clr_stats, stat_br,
//   stat_miss                    statistics
module branch_resolve_bht #(
  parameter int         DATA_W    = 32,
  parameter int         BHT_DEPTH = 64,
  parameter int         IDX_W     = 6,
  parameter logic [1:0] CNT_INIT  = 2'b01
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [31:0]       f_pc,
  output logic              f_pred_taken,
  input  logic              d_valid,
  input  logic              d_stall,
  input  logic              d_is_br,
  input  logic [5:0]        d_opcode,
  input  logic [4:0]        d_rt,
  input  logic [31:0]       d_pc,
  input  logic              d_pred_taken,
  input  logic [DATA_W-1:0] d_rd1,
  input  logic [DATA_W-1:0] d_rd2,
  output logic              br_taken,
  output logic              br_link,
  output logic              mispredict,
  input  logic              clr_stats,
  output logic [31:0]       stat_br,
  output logic [31:0]       stat_miss
);
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;

  logic [BHT_DEPTH-1:0][1:0] cnt_q, cnt_d;
  logic [31:0]               stat_br_q, stat_br_d, stat_miss_q, stat_miss_d;
  logic [IDX_W-1:0]          f_idx, d_idx;
  logic [1:0]                cur_cnt, upd_cnt;
  logic                      cond, act, rd1_neg, rd1_zero;

  assign f_idx    = f_pc[IDX_W+1:2];
  assign d_idx    = d_pc[IDX_W+1:2];
  assign rd1_neg  = d_rd1[DATA_W-1];
  assign rd1_zero = (d_rd1 == '0);

  always_comb begin
    cond = 1'b0;
    case (d_opcode)
      OP_BEQ:  cond = (d_rd1 == d_rd2);
      OP_BNE:  cond = (d_rd1 != d_rd2);
      OP_BLEZ: cond = rd1_neg | rd1_zero;
      OP_BGTZ: cond = ~rd1_neg & ~rd1_zero;
      OP_REGIMM: begin
        case (d_rt)
          5'b00000, 5'b10000: cond = rd1_neg;
          5'b00001, 5'b10001: cond = ~rd1_neg;
          default:            cond = 1'b0;
        endcase
      end
      default: cond = 1'b0;
    endcase
  end

  assign act        = d_valid & d_is_br & ~d_stall;
  assign br_taken   = act & cond;
  assign br_link    = act & (d_opcode == OP_REGIMM) & d_rt[4];
  assign mispredict = act & (cond ^ d_pred_taken);

  // saturating step of the entry owned by the resolving branch
  assign cur_cnt = cnt_q[d_idx];
  always_comb begin
    if (cond) upd_cnt = (cur_cnt == 2'b11) ? 2'b11 : cur_cnt + 2'd1;
    else      upd_cnt = (cur_cnt == 2'b00) ? 2'b00 : cur_cnt - 2'd1;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (act) cnt_d[d_idx] = upd_cnt;
  end

  // bypass lets F see this cycle's write; forced to the init value while in
  // reset so a branch still presented on D cannot leak through
  always_comb begin
    if (!reset_n)                  f_pred_taken = CNT_INIT[1];
    else if (act && f_idx == d_idx) f_pred_taken = upd_cnt[1];
    else                           f_pred_taken = cnt_q[f_idx][1];
  end

  always_comb begin
    stat_br_d   = stat_br_q;
    stat_miss_d = stat_miss_q;
    if (clr_stats) begin
      stat_br_d   = '0;
      stat_miss_d = '0;
    end else begin
      if (act && stat_br_q != '1)          stat_br_d   = stat_br_q + 32'd1;
      if (mispredict && stat_miss_q != '1) stat_miss_d = stat_miss_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q       <= {BHT_DEPTH{CNT_INIT}};
      stat_br_q   <= '0;
      stat_miss_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      stat_br_q   <= stat_br_d;
      stat_miss_q <= stat_miss_d;
    end
  end

  assign stat_br   = stat_br_q;
  assign stat_miss = stat_miss_q;

  // PC bits outside the index field are intentionally ignored (no tags)
  logic unused_pc_bits;
  assign unused_pc_bits = ^{f_pc[31:IDX_W+2], f_pc[1:0], d_pc[31:IDX_W+2], d_pc[1:0]};
endmodule

// File: tb/tb_branch_resolve_bht.sv
module tb_branch_resolve_bht;
  logic        clk = 1'b0, reset_n = 1'b0;
  logic [31:0] f_pc = '0, d_pc = '0, d_rd1 = '0, d_rd2 = '0;
  logic        f_pred_taken, d_valid = 0, d_stall = 0, d_is_br = 0, d_pred_taken = 0;
  logic [5:0]  d_opcode = '0;
  logic [4:0]  d_rt = '0;
  logic        br_taken, br_link, mispredict, clr_stats = 0;
  logic [31:0] stat_br, stat_miss;

  int n_pass = 0, n_tot = 0;

  branch_resolve_bht dut (
    .clk(clk), .reset_n(reset_n), .f_pc(f_pc), .f_pred_taken(f_pred_taken),
    .d_valid(d_valid), .d_stall(d_stall), .d_is_br(d_is_br), .d_opcode(d_opcode),
    .d_rt(d_rt), .d_pc(d_pc), .d_pred_taken(d_pred_taken), .d_rd1(d_rd1), .d_rd2(d_rd2),
    .br_taken(br_taken), .br_link(br_link), .mispredict(mispredict),
    .clr_stats(clr_stats), .stat_br(stat_br), .stat_miss(stat_miss)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic drive(input logic v, input logic br, input logic st, input logic [5:0] op,
                       input logic [4:0] rt, input logic [31:0] a, input logic [31:0] b,
                       input logic pred, input logic [31:0] pc);
    d_valid = v; d_is_br = br; d_stall = st; d_opcode = op; d_rt = rt;
    d_rd1 = a; d_rd2 = b; d_pred_taken = pred; d_pc = pc;
  endtask

  task automatic idle();
    d_valid = 0; d_is_br = 0; d_stall = 0;
  endtask

  task automatic do_reset();
    @(negedge clk); idle(); clr_stats = 0; reset_n = 0;
    @(negedge clk); reset_n = 1;
  endtask

  typedef struct packed {
    logic v, br, st;
    logic [5:0] op;
    logic [4:0] rt;
    logic [31:0] a, b;
    logic pred, et, el, em;
  } vec_t;

  vec_t vecs[18];
  int exp_br, exp_miss;

  initial begin
    //           v  br st  op         rt        a              b          pred t l m
    vecs[0]  = '{1, 1, 0, 6'b000100, 5'b00000, 32'd5,         32'd5, 1'b0, 1,0,1};
    vecs[1]  = '{1, 1, 0, 6'b000100, 5'b00000, 32'd5,         32'd6, 1'b0, 0,0,0};
    vecs[2]  = '{1, 1, 0, 6'b000101, 5'b00000, 32'd5,         32'd6, 1'b1, 1,0,0};
    vecs[3]  = '{1, 1, 0, 6'b000110, 5'b00000, 32'h8000_0000, 32'd0, 1'b0, 1,0,1};
    vecs[4]  = '{1, 1, 0, 6'b000110, 5'b00000, 32'd0,         32'd0, 1'b1, 1,0,0};
    vecs[5]  = '{1, 1, 0, 6'b000110, 5'b00000, 32'd1,         32'd0, 1'b0, 0,0,0};
    vecs[6]  = '{1, 1, 0, 6'b000111, 5'b00000, 32'd0,         32'd0, 1'b1, 0,0,1};
    vecs[7]  = '{1, 1, 0, 6'b000111, 5'b00000, 32'h7FFF_FFFF, 32'd0, 1'b1, 1,0,0};
    vecs[8]  = '{1, 1, 0, 6'b000001, 5'b00000, 32'hFFFF_FFFF, 32'd0, 1'b0, 1,0,1};
    vecs[9]  = '{1, 1, 0, 6'b000001, 5'b00000, 32'd0,         32'd0, 1'b0, 0,0,0};
    vecs[10] = '{1, 1, 0, 6'b000001, 5'b00001, 32'd0,         32'd0, 1'b0, 1,0,1};
    vecs[11] = '{1, 1, 0, 6'b000001, 5'b10000, 32'd5,         32'd0, 1'b0, 0,1,0};
    vecs[12] = '{1, 1, 0, 6'b000001, 5'b10001, 32'd5,         32'd0, 1'b0, 1,1,1};
    vecs[13] = '{1, 1, 0, 6'b000001, 5'b00010, 32'hFFFF_FFFF, 32'd0, 1'b1, 0,0,1};
    vecs[14] = '{1, 1, 0, 6'b000000, 5'b00000, 32'd3,         32'd3, 1'b1, 0,0,1};
    vecs[15] = '{0, 1, 0, 6'b000100, 5'b00000, 32'd5,         32'd5, 1'b0, 0,0,0};
    vecs[16] = '{1, 0, 0, 6'b000100, 5'b00000, 32'd5,         32'd5, 1'b0, 0,0,0};
    vecs[17] = '{1, 1, 1, 6'b000001, 5'b10001, 32'd5,         32'd0, 1'b1, 0,0,0};

    // reset state, observed before any clock edge
    f_pc = 32'h2000;
    #1;
    chk("reset f_pred", {31'd0, f_pred_taken}, 32'd0);
    chk("reset stat_br", stat_br, 32'd0);
    chk("reset stat_miss", stat_miss, 32'd0);
    @(negedge clk); reset_n = 1;

    // 1: taken BEQ predicted not-taken; bypass then stored value
    @(negedge clk);
    drive(1, 1, 0, 6'b000100, 5'b00000, 32'd5, 32'd5, 1'b0, 32'h2000);
    #1;
    chk("t1 br_taken", {31'd0, br_taken}, 32'd1);
    chk("t1 mispredict", {31'd0, mispredict}, 32'd1);
    chk("t1 br_link", {31'd0, br_link}, 32'd0);
    chk("t1 bypass", {31'd0, f_pred_taken}, 32'd1);
    @(negedge clk); idle(); #1;
    chk("t1 stored pred", {31'd0, f_pred_taken}, 32'd1);
    chk("t1 stat_br", stat_br, 32'd1);
    chk("t1 stat_miss", stat_miss, 32'd1);

    // 2: compare table (index 1 entry, F looks elsewhere)
    do_reset();
    f_pc = 32'h0; exp_br = 0; exp_miss = 0;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      drive(vecs[i].v, vecs[i].br, vecs[i].st, vecs[i].op, vecs[i].rt,
            vecs[i].a, vecs[i].b, vecs[i].pred, 32'h104);
      #1;
      chk($sformatf("vec%0d br_taken", i), {31'd0, br_taken}, {31'd0, vecs[i].et});
      chk($sformatf("vec%0d br_link", i), {31'd0, br_link}, {31'd0, vecs[i].el});
      chk($sformatf("vec%0d mispredict", i), {31'd0, mispredict}, {31'd0, vecs[i].em});
      if (vecs[i].v && vecs[i].br && !vecs[i].st) exp_br++;
      if (vecs[i].em) exp_miss++;
    end
    @(negedge clk); idle(); #1;
    chk("table stat_br", stat_br, exp_br);
    chk("table stat_miss", stat_miss, exp_miss);

    // 3: saturation at 11, then one step down
    do_reset();
    f_pc = 32'h3000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); drive(1, 1, 0, 6'b000100, 5'b0, 32'd1, 32'd1, 1'b1, 32'h3000);
    end
    @(negedge clk); drive(1, 1, 0, 6'b000100, 5'b0, 32'd1, 32'd2, 1'b1, 32'h3000);
    @(negedge clk); idle(); #1;
    chk("t3 after 4T1N pred", {31'd0, f_pred_taken}, 32'd1);
    @(negedge clk); drive(1, 1, 0, 6'b000100, 5'b0, 32'd1, 32'd2, 1'b1, 32'h3000);
    @(negedge clk); idle(); #1;
    chk("t3 after 4T2N pred", {31'd0, f_pred_taken}, 32'd0);

    // 4: stalled branch updates exactly once on release
    do_reset();
    f_pc = 32'h3000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); drive(1, 1, 1, 6'b000100, 5'b0, 32'd7, 32'd7, 1'b0, 32'h3000); #1;
      chk($sformatf("t4 stall%0d br_taken", i), {31'd0, br_taken}, 32'd0);
    end
    @(negedge clk); #1;
    chk("t4 stalled pred", {31'd0, f_pred_taken}, 32'd0);
    chk("t4 stalled stat_br", stat_br, 32'd0);
    d_stall = 0; #1;
    chk("t4 release br_taken", {31'd0, br_taken}, 32'd1);
    @(negedge clk); idle(); #1;
    chk("t4 release pred", {31'd0, f_pred_taken}, 32'd1);
    chk("t4 release stat_br", stat_br, 32'd1);
    @(negedge clk); drive(1, 1, 0, 6'b000100, 5'b0, 32'd7, 32'd8, 1'b1, 32'h3000);
    @(negedge clk); idle(); #1;
    chk("t4 single update", {31'd0, f_pred_taken}, 32'd0);

    // 5: aliasing F/D PCs, bypass in the same cycle
    do_reset();
    f_pc = 32'h3100;
    @(negedge clk); #1;
    chk("t5 pre pred", {31'd0, f_pred_taken}, 32'd0);
    drive(1, 1, 0, 6'b000100, 5'b0, 32'd9, 32'd9, 1'b0, 32'h3000); #1;
    chk("t5 bypass", {31'd0, f_pred_taken}, 32'd1);

    // 6: async reset between edges, with a branch still on D
    @(negedge clk); #1;
    chk("t6 pre stat_br", stat_br, 32'd1);
    #2 reset_n = 0; #1;
    chk("t6 async pred", {31'd0, f_pred_taken}, 32'd0);
    chk("t6 async stat_br", stat_br, 32'd0);
    chk("t6 async stat_miss", stat_miss, 32'd0);
    @(negedge clk); idle();
    @(negedge clk); reset_n = 1; #1;
    chk("t6 discarded update", {31'd0, f_pred_taken}, 32'd0);

    // stat_br saturation
    force dut.stat_br_q = 32'hFFFF_FFFF;
    @(negedge clk); release dut.stat_br_q;
    drive(1, 1, 0, 6'b000100, 5'b0, 32'd1, 32'd1, 1'b0, 32'h200);
    @(negedge clk); idle(); #1;
    chk("t6 stat_br saturates", stat_br, 32'hFFFF_FFFF);
    chk("t6 stat_miss counts", stat_miss, 32'd1);

    // clr_stats wins over an active branch
    @(negedge clk); clr_stats = 1;
    drive(1, 1, 0, 6'b000100, 5'b0, 32'd1, 32'd1, 1'b0, 32'h200);
    @(negedge clk); idle(); clr_stats = 0; #1;
    chk("clr stat_br", stat_br, 32'd0);
    chk("clr stat_miss", stat_miss, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
